// File: rtl/csi2_pkg.sv
// Shared CSI-2 definitions: data types, sync byte, CRC constants, FSM/packet enums, header ECC.
// Latency: n/a (constants, types and a pure combinational function).
// Backpressure: n/a.
//
// Contents:
//   DT_FS / DT_FE / DT_RAW8  data-type codes
//   SYNC_BYTE                leader byte sent on every lane at start of an HS burst
//   CRC_SEED / CRC_POLY      reflected CRC-16 (0x1021 bit-reversed)
//   state_t / pkt_t          transmitter FSM state and current packet kind
//   hdr_t                    packet header {ecc, wc, di}
//   ecc24()                  CSI-2 Hamming ECC over {WC, DI}; also used by the receiver header check
package csi2_pkg;

    localparam logic [5:0]  DT_FS     = 6'h00;
    localparam logic [5:0]  DT_FE     = 6'h01;
    localparam logic [5:0]  DT_RAW8   = 6'h2A;
    localparam logic [7:0]  SYNC_BYTE = 8'hB8;
    localparam logic [15:0] CRC_SEED  = 16'hFFFF;
    localparam logic [15:0] CRC_POLY  = 16'h8408;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_SYNC,
        ST_HDR0,
        ST_HDR1,
        ST_PAYLOAD,
        ST_CRC,
        ST_GAP
    } state_t;

    typedef enum logic [1:0] {
        PK_FS,
        PK_LINE,
        PK_FE
    } pkt_t;

    typedef struct packed {
        logic [7:0]  ecc;
        logic [15:0] wc;
        logic [7:0]  di;
    } hdr_t;

    // d = {WC[15:0], DI[7:0]}; d[0] is DI bit 0. The two top ECC bits are reserved as 0.
    function automatic logic [7:0] ecc24(input logic [23:0] d);
        logic [5:0] p;
        p[0] = d[0]  ^ d[1]  ^ d[2]  ^ d[4]  ^ d[5]  ^ d[7]  ^ d[10] ^ d[11] ^ d[13] ^ d[16]
             ^ d[20] ^ d[21] ^ d[22] ^ d[23];
        p[1] = d[0]  ^ d[1]  ^ d[3]  ^ d[4]  ^ d[6]  ^ d[8]  ^ d[10] ^ d[12] ^ d[14] ^ d[17]
             ^ d[20] ^ d[21] ^ d[22] ^ d[23];
        p[2] = d[0]  ^ d[2]  ^ d[3]  ^ d[5]  ^ d[6]  ^ d[9]  ^ d[11] ^ d[12] ^ d[15] ^ d[18]
             ^ d[20] ^ d[21] ^ d[22];
        p[3] = d[1]  ^ d[2]  ^ d[3]  ^ d[7]  ^ d[8]  ^ d[9]  ^ d[13] ^ d[14] ^ d[15] ^ d[19]
             ^ d[20] ^ d[21] ^ d[23];
        p[4] = d[4]  ^ d[5]  ^ d[6]  ^ d[7]  ^ d[8]  ^ d[9]  ^ d[16] ^ d[17] ^ d[18] ^ d[19]
             ^ d[20] ^ d[22] ^ d[23];
        p[5] = d[10] ^ d[11] ^ d[12] ^ d[13] ^ d[14] ^ d[15] ^ d[16] ^ d[17] ^ d[18] ^ d[19]
             ^ d[21] ^ d[22] ^ d[23];
        return {2'b00, p};
    endfunction

endpackage

// File: rtl/csi2_crc16_2b.sv
// Two-bytes-per-cycle update of the reflected CSI-2 payload CRC-16 (b0 first, then b1).
// Latency: combinational, zero cycles.
// Backpressure: none; the caller decides when to register crc_out.
//
// Ports:
//   crc_in  [15:0]  running CRC before this beat
//   b0      [7:0]   first payload byte of the beat (lane 0)
//   b1      [7:0]   second payload byte of the beat (lane 1)
//   crc_out [15:0]  running CRC after both bytes
module csi2_crc16_2b
    import csi2_pkg::*;
(
    input  logic [15:0] crc_in,
    input  logic [7:0]  b0,
    input  logic [7:0]  b1,
    output logic [15:0] crc_out
);

    logic [15:0] c;

    // Bytes enter LSB first, so the register shifts right and feeds back the reflected polynomial.
    always_comb begin
        c = crc_in;
        for (int i = 0; i < 8; i++) begin
            c = (c[0] ^ b0[i]) ? ((c >> 1) ^ CRC_POLY) : (c >> 1);
        end
        for (int i = 0; i < 8; i++) begin
            c = (c[0] ^ b1[i]) ? ((c >> 1) ^ CRC_POLY) : (c >> 1);
        end
        crc_out = c;
    end

endmodule

// File: rtl/csi2_byte_tx.sv
// Two-lane CSI-2 byte-level frame transmitter: FS, LINES RAW8 line packets, FE, each with gap.
// Latency: frame_go -> SYNC on the lanes next cycle; payload beats pass to the lanes in the accept cycle.
// Backpressure: none inside a packet; a missing pix_valid beat is sent as 0x00 and flagged in underrun.
//
// Ports:
//   sys_clk                 byte clock, rising edge
//   reset                   asynchronous, active-high
//   frame_go                start-of-frame pulse, accepted only in IDLE
//   pix_data[15:0]/pix_valid payload beat ([7:0] -> lane 0, [15:8] -> lane 1)
//   pix_ready               high in every PAYLOAD cycle; the beat present is consumed that cycle
//   lane0_byte/lane1_byte   lane byte buses to the HS serializer
//   hs_active               high from SYNC through the last byte of a packet
//   busy                    frame in progress
//   underrun                sticky zero-fill flag, cleared by an accepted frame_go
//   frame_cnt[15:0]         frame number carried in FS/FE WC, 1..FFFF
// Build option: CSI2_TX_TESTPAT_EN replaces pix_data/pix_valid with an internal ramp generator.
module csi2_byte_tx
    import csi2_pkg::*;
#(
    parameter int unsigned LINE_BYTES = 640,
    parameter int unsigned LINES      = 480,
    parameter logic [1:0]  VC         = 2'd0,
    parameter logic [5:0]  DT_LINE    = DT_RAW8,
    parameter int unsigned LP_GAP     = 8
) (
    input  logic        sys_clk,
    input  logic        reset,
    input  logic        frame_go,
    input  logic [15:0] pix_data,
    input  logic        pix_valid,
    output logic        pix_ready,
    output logic [7:0]  lane0_byte,
    output logic [7:0]  lane1_byte,
    output logic        hs_active,
    output logic        busy,
    output logic        underrun,
    output logic [15:0] frame_cnt
);

    localparam int unsigned BEATS  = LINE_BYTES / 2;
    localparam int unsigned BEAT_W = (BEATS  > 1) ? $clog2(BEATS)  : 1;
    localparam int unsigned LINE_W = (LINES  > 1) ? $clog2(LINES)  : 1;
    localparam int unsigned GAP_W  = (LP_GAP > 1) ? $clog2(LP_GAP) : 1;

    localparam logic [BEAT_W-1:0] BEAT_LAST = BEAT_W'(BEATS - 1);
    localparam logic [LINE_W-1:0] LINE_LAST = LINE_W'(LINES - 1);
    localparam logic [GAP_W-1:0]  GAP_LAST  = GAP_W'(LP_GAP - 1);

    state_t              state;
    pkt_t                pkt;
    logic [LINE_W-1:0]   line_cnt;
    logic [BEAT_W-1:0]   beat_cnt;
    logic [GAP_W-1:0]    gap_cnt;
    logic [7:0]          lane0_q;
    logic [7:0]          lane1_q;
    logic [15:0]         crc_q;
    logic [15:0]         crc_nxt;
    logic [7:0]          beat0;
    logic [7:0]          beat1;
    logic                beat_ok;
    hdr_t                hdr;

    // Header of the packet currently being sent; FS and FE both carry the frame number.
    always_comb begin
        hdr = '0;
        case (pkt)
            PK_FS: begin
                hdr.di = {VC, DT_FS};
                hdr.wc = frame_cnt;
            end
            PK_FE: begin
                hdr.di = {VC, DT_FE};
                hdr.wc = frame_cnt;
            end
            default: begin
                hdr.di = {VC, DT_LINE};
                hdr.wc = 16'(LINE_BYTES);
            end
        endcase
        hdr.ecc = ecc24({hdr.wc, hdr.di});
    end

`ifdef CSI2_TX_TESTPAT_EN
    // Ramp: lane0 = col + line, lane1 = col + 1 + line, col = byte index within the line.
    logic [7:0] pat_base;
    assign pat_base = 8'({beat_cnt, 1'b0}) + 8'(line_cnt);
    assign beat0    = pat_base;
    assign beat1    = pat_base + 8'd1;
    assign beat_ok  = 1'b1;
`else
    assign beat0    = pix_valid ? pix_data[7:0]  : 8'h00;
    assign beat1    = pix_valid ? pix_data[15:8] : 8'h00;
    assign beat_ok  = pix_valid;
`endif

    csi2_crc16_2b u_crc (
        .crc_in  (crc_q),
        .b0      (beat0),
        .b1      (beat1),
        .crc_out (crc_nxt)
    );

    // Payload bytes bypass the lane registers so the beat accepted this cycle is the one on the
    // lanes; every other byte (sync, header, CRC, idle) comes from the lane registers.
    assign lane0_byte = (state == ST_PAYLOAD) ? beat0 : lane0_q;
    assign lane1_byte = (state == ST_PAYLOAD) ? beat1 : lane1_q;

    always_ff @(posedge sys_clk or posedge reset) begin
        if (reset) begin
            state     <= ST_IDLE;
            pkt       <= PK_FS;
            line_cnt  <= '0;
            beat_cnt  <= '0;
            gap_cnt   <= '0;
            lane0_q   <= 8'h00;
            lane1_q   <= 8'h00;
            crc_q     <= CRC_SEED;
            pix_ready <= 1'b0;
            hs_active <= 1'b0;
            busy      <= 1'b0;
            underrun  <= 1'b0;
            frame_cnt <= 16'h0001;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (frame_go) begin
                        state     <= ST_SYNC;
                        pkt       <= PK_FS;
                        line_cnt  <= '0;
                        busy      <= 1'b1;
                        underrun  <= 1'b0;
                        hs_active <= 1'b1;
                        lane0_q   <= SYNC_BYTE;
                        lane1_q   <= SYNC_BYTE;
                    end
                end
                ST_SYNC: begin
                    state   <= ST_HDR0;
                    lane0_q <= hdr.di;
                    lane1_q <= hdr.wc[7:0];
                end
                ST_HDR0: begin
                    state   <= ST_HDR1;
                    lane0_q <= hdr.wc[15:8];
                    lane1_q <= hdr.ecc;
                end
                ST_HDR1: begin
                    crc_q   <= CRC_SEED;
                    lane0_q <= 8'h00;
                    lane1_q <= 8'h00;
                    if (pkt == PK_LINE) begin
                        state     <= ST_PAYLOAD;
                        beat_cnt  <= '0;
                        pix_ready <= 1'b1;
                    end else begin
                        state     <= ST_GAP;
                        gap_cnt   <= '0;
                        hs_active <= 1'b0;
                    end
                end
                ST_PAYLOAD: begin
                    crc_q    <= crc_nxt;
                    beat_cnt <= beat_cnt + 1'b1;
                    if (!beat_ok) begin
                        underrun <= 1'b1;
                    end
                    // The final beat's CRC goes straight into the lane registers for the CRC cycle.
                    if (beat_cnt == BEAT_LAST) begin
                        state     <= ST_CRC;
                        pix_ready <= 1'b0;
                        lane0_q   <= crc_nxt[7:0];
                        lane1_q   <= crc_nxt[15:8];
                    end
                end
                ST_CRC: begin
                    state     <= ST_GAP;
                    gap_cnt   <= '0;
                    hs_active <= 1'b0;
                    lane0_q   <= 8'h00;
                    lane1_q   <= 8'h00;
                end
                ST_GAP: begin
                    if (gap_cnt == GAP_LAST) begin
                        gap_cnt <= '0;
                        if (pkt == PK_FE) begin
                            state     <= ST_IDLE;
                            busy      <= 1'b0;
                            frame_cnt <= (frame_cnt == 16'hFFFF) ? 16'h0001 : frame_cnt + 16'd1;
                        end else begin
                            state     <= ST_SYNC;
                            hs_active <= 1'b1;
                            lane0_q   <= SYNC_BYTE;
                            lane1_q   <= SYNC_BYTE;
                            if (pkt == PK_FS) begin
                                pkt      <= PK_LINE;
                                line_cnt <= '0;
                            end else if (line_cnt == LINE_LAST) begin
                                pkt <= PK_FE;
                            end else begin
                                line_cnt <= line_cnt + 1'b1;
                            end
                        end
                    end else begin
                        gap_cnt <= gap_cnt + 1'b1;
                    end
                end
                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_csi2_byte_tx.sv
// Scoreboard bench for csi2_byte_tx: expected lane bytes queued at stimulus, popped by a monitor.
// Latency: n/a.
// Backpressure: n/a.
module tb_csi2_byte_tx;
    import csi2_pkg::*;

    localparam int LB  = 24;
    localparam int NL  = 2;
    localparam int GAP = 8;

    logic        sys_clk = 1'b0;
    logic        reset = 1'b1;
    logic        frame_go = 1'b0;
    logic [15:0] pix_data = 16'h0000;
    logic        pix_valid = 1'b0;
    logic        pix_ready;
    logic [7:0]  lane0_byte;
    logic [7:0]  lane1_byte;
    logic        hs_active;
    logic        busy;
    logic        underrun;
    logic [15:0] frame_cnt;

    csi2_byte_tx #(
        .LINE_BYTES (LB),
        .LINES      (NL),
        .VC         (2'd0),
        .DT_LINE    (6'h2A),
        .LP_GAP     (GAP)
    ) dut (
        .sys_clk    (sys_clk),
        .reset      (reset),
        .frame_go   (frame_go),
        .pix_data   (pix_data),
        .pix_valid  (pix_valid),
        .pix_ready  (pix_ready),
        .lane0_byte (lane0_byte),
        .lane1_byte (lane1_byte),
        .hs_active  (hs_active),
        .busy       (busy),
        .underrun   (underrun),
        .frame_cnt  (frame_cnt)
    );

    always #5 sys_clk = ~sys_clk;

    int errors = 0;
    int checks = 0;

    logic [15:0] exp_q[$];   // {lane1, lane0} for every hs_active cycle
    logic [16:0] beat_q[$];  // {valid, pix_data} handed out on pix_ready

    int   pkt_cnt = 0;
    int   gap_run = 0;
    logic hs_prev = 1'b0;

    logic [7:0] ref_v [24] = '{8'hFF, 8'h00, 8'h00, 8'h02, 8'hB9, 8'hDC, 8'hF3, 8'h72,
                               8'hBB, 8'hD4, 8'hB8, 8'h5A, 8'hC8, 8'h75, 8'hC2, 8'h7C,
                               8'h81, 8'hF8, 8'h05, 8'hDF, 8'hFF, 8'h00, 8'h00, 8'h01};

    // Hamming column codes: syndrome contributed by each of the 24 header bits.
    logic [5:0] syn [24] = '{6'h07, 6'h0B, 6'h0D, 6'h0E, 6'h13, 6'h15, 6'h16, 6'h19,
                             6'h1A, 6'h1C, 6'h23, 6'h25, 6'h26, 6'h29, 6'h2A, 6'h2C,
                             6'h31, 6'h32, 6'h34, 6'h38, 6'h1F, 6'h2F, 6'h37, 6'h3B};

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, want 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic logic [7:0] ecc_model(input logic [23:0] d);
        logic [5:0] e;
        e = 6'h00;
        for (int i = 0; i < 24; i++) begin
            if (d[i]) e = e ^ syn[i];
        end
        return {2'b00, e};
    endfunction

    function automatic logic [15:0] crc_bits(input logic [15:0] c, input logic [7:0] b);
        logic [15:0] r;
        r = c;
        for (int k = 0; k < 8; k++) begin
            if (r[0] ^ b[k]) r = (r >> 1) ^ 16'h8408;
            else             r = r >> 1;
        end
        return r;
    endfunction

    function automatic logic [7:0] pdata(input int kind, input int l, input int i);
        if (kind == 0 && l == 0) return ref_v[i];
        return 8'(i * 7 + l * 29 + kind * 13 + 3);
    endfunction

    task automatic push_hdr(input logic [7:0] di, input logic [15:0] wc);
        exp_q.push_back({8'hB8, 8'hB8});
        exp_q.push_back({wc[7:0], di});
        exp_q.push_back({ecc_model({wc, di}), wc[15:8]});
    endtask

    // Queue one frame's expected bytes and payload beats, then pulse frame_go.
    // bad_beat >= 0 drops pix_valid for that beat of line 0.
    task automatic send_frame(input int kind, input int bad_beat, input logic [15:0] fc);
        logic [15:0] c;
        logic [7:0]  b0;
        logic [7:0]  b1;
        logic        v;
        push_hdr(8'h00, fc);
        for (int l = 0; l < NL; l++) begin
            push_hdr(8'h2A, 16'(LB));
            c = 16'hFFFF;
            for (int b = 0; b < LB / 2; b++) begin
                b0 = pdata(kind, l, 2 * b);
                b1 = pdata(kind, l, 2 * b + 1);
                v  = !(l == 0 && b == bad_beat);
                beat_q.push_back({v, b1, b0});
                if (!v) begin
                    b0 = 8'h00;
                    b1 = 8'h00;
                end
                exp_q.push_back({b1, b0});
                c = crc_bits(crc_bits(c, b0), b1);
            end
            if (kind == 0 && l == 0) exp_q.push_back({8'h00, 8'hF0});
            else                     exp_q.push_back(c);
        end
        push_hdr(8'h01, fc);
        frame_go = 1'b1;
        @(posedge sys_clk);
        #1;
        frame_go = 1'b0;
        check("busy_after_go", 32'(busy), 32'd1);
    endtask

    task automatic wait_idle();
        for (int i = 0; i < 1000 && busy; i++) @(negedge sys_clk);
        check("frame_done", 32'(busy), 32'd0);
    endtask

    // Payload driver: hands out one queued beat per pix_ready cycle.
    always @(posedge sys_clk) begin
        #1;
        if (pix_ready && beat_q.size() > 0) begin
            {pix_valid, pix_data} = beat_q.pop_front();
        end else begin
            pix_valid = 1'b0;
            pix_data  = 16'h0000;
        end
    end

    // Monitor: compares every HS byte pair and measures the idle gap between packets.
    always @(negedge sys_clk) begin
        logic [15:0] e;
        if (reset) begin
            gap_run = 0;
            hs_prev = 1'b0;
        end else begin
            if (hs_active) begin
                if (!hs_prev) begin
                    pkt_cnt++;
                    if (gap_run != 0) check("gap_len", 32'(gap_run), 32'(GAP));
                    gap_run = 0;
                end
                if (exp_q.size() == 0) begin
                    check("unexpected_hs_byte", 32'({lane1_byte, lane0_byte}), 32'hFFFF_FFFF);
                end else begin
                    e = exp_q.pop_front();
                    check("lane_bytes", 32'({lane1_byte, lane0_byte}), 32'(e));
                end
            end else if (busy) begin
                check("idle_lanes", 32'({lane1_byte, lane0_byte}), 32'd0);
                gap_run++;
            end else if (gap_run != 0) begin
                check("gap_len_fe", 32'(gap_run), 32'(GAP));
                gap_run = 0;
            end
            hs_prev = hs_active;
        end
    end

    initial begin
        #60000;
        $display("FAIL watchdog: simulation did not finish, errors=%0d", errors);
        $fatal(1);
    end

    initial begin
        int base;
        repeat (3) @(posedge sys_clk);
        #1;
        reset = 1'b0;
        @(negedge sys_clk);
        check("rst_hs_active", 32'(hs_active), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_pix_ready", 32'(pix_ready), 32'd0);
        check("rst_lanes", 32'({lane1_byte, lane0_byte}), 32'd0);
        check("rst_underrun", 32'(underrun), 32'd0);
        check("rst_frame_cnt", 32'(frame_cnt), 32'h0001);

        check("ecc_di01", 32'(ecc24(24'h000001)), 32'h07);
        check("ecc_di02", 32'(ecc24(24'h000002)), 32'h0B);
        check("ecc_line_hdr", 32'(ecc24({16'd24, 8'h2A})), 32'h13);
        check("ecc_fe_hdr", 32'(ecc24({16'h0001, 8'h01})), 32'(ecc_model({16'h0001, 8'h01})));

        // Frame 1: reference CRC line, plus a frame_go mid-frame that must be dropped.
        @(posedge sys_clk);
        #1;
        base = pkt_cnt;
        send_frame(0, -1, 16'h0001);
        repeat (20) @(posedge sys_clk);
        #1;
        frame_go = 1'b1;
        @(posedge sys_clk);
        #1;
        frame_go = 1'b0;
        wait_idle();
        check("f1_packets", 32'(pkt_cnt - base), 32'(NL + 2));
        check("f1_frame_cnt", 32'(frame_cnt), 32'h0002);
        check("f1_underrun", 32'(underrun), 32'd0);
        check("f1_exp_left", 32'(exp_q.size()), 32'd0);

        // Frame 2: one invalid beat mid-line -> zero-filled, sticky underrun.
        @(posedge sys_clk);
        #1;
        base = pkt_cnt;
        send_frame(1, 5, 16'h0002);
        wait_idle();
        check("f2_underrun", 32'(underrun), 32'd1);
        check("f2_packets", 32'(pkt_cnt - base), 32'(NL + 2));
        check("f2_frame_cnt", 32'(frame_cnt), 32'h0003);
        check("f2_exp_left", 32'(exp_q.size()), 32'd0);

        // Frame 3: accepted frame_go clears underrun; frame_go in the final GAP cycle is ignored.
        @(posedge sys_clk);
        #1;
        base = pkt_cnt;
        send_frame(2, -1, 16'h0003);
        check("f3_underrun_cleared", 32'(underrun), 32'd0);
        for (int i = 0; i < 1000 && exp_q.size() != 0; i++) begin
            @(posedge sys_clk);
            #2;
        end
        check("f3_all_bytes_seen", 32'(exp_q.size()), 32'd0);
        repeat (7) @(posedge sys_clk);
        #1;
        frame_go = 1'b1;
        @(posedge sys_clk);
        #1;
        frame_go = 1'b0;
        repeat (3) @(negedge sys_clk);
        check("f3_late_go_busy", 32'(busy), 32'd0);
        check("f3_late_go_hs", 32'(hs_active), 32'd0);
        check("f3_frame_cnt", 32'(frame_cnt), 32'h0004);
        check("f3_packets", 32'(pkt_cnt - base), 32'(NL + 2));

        // Frame 4: reset in the middle of the first line's payload.
        @(posedge sys_clk);
        #1;
        send_frame(3, -1, 16'h0004);
        for (int i = 0; i < 200 && !pix_ready; i++) begin
            @(posedge sys_clk);
            #1;
        end
        check("f4_in_payload", 32'(pix_ready), 32'd1);
        repeat (3) @(posedge sys_clk);
        #3;
        reset = 1'b1;
        #1;
        check("rst_mid_hs_active", 32'(hs_active), 32'd0);
        check("rst_mid_busy", 32'(busy), 32'd0);
        check("rst_mid_pix_ready", 32'(pix_ready), 32'd0);
        check("rst_mid_lanes", 32'({lane1_byte, lane0_byte}), 32'd0);
        exp_q.delete();
        beat_q.delete();
        repeat (2) @(posedge sys_clk);
        #1;
        reset = 1'b0;
        @(negedge sys_clk);
        check("rst_mid_frame_cnt", 32'(frame_cnt), 32'h0001);
        check("rst_mid_idle_hs", 32'(hs_active), 32'd0);

        // Frame 5: clean frame after the reset.
        @(posedge sys_clk);
        #1;
        base = pkt_cnt;
        send_frame(4, -1, 16'h0001);
        wait_idle();
        check("f5_packets", 32'(pkt_cnt - base), 32'(NL + 2));
        check("f5_frame_cnt", 32'(frame_cnt), 32'h0002);
        check("f5_exp_left", 32'(exp_q.size()), 32'd0);

        repeat (4) @(posedge sys_clk);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
